// File: rtl/opn_inject_queue_pkg.sv
// Shared operand-network types: result data, instruction numbers, operands,
// hop directions and the queued packet format.
package opn_inject_queue_pkg;

    localparam int GRID_DIM = 4;
    localparam int DATA_W   = 32;
    localparam int INSTR_W  = 7;
    localparam int COORD_W  = $clog2(GRID_DIM);
    localparam int NODE_W   = 2 * COORD_W;

    typedef logic [DATA_W-1:0]  reg_data_t;
    typedef logic [INSTR_W-1:0] instr_num_t;
    typedef logic [1:0]         slot_t;

    // Slot encoding 3 has no operand buffer behind it; such targets are dropped.
    localparam slot_t SLOT_ILLEGAL = 2'd3;

    typedef enum logic [2:0] {
        DIR_LOCAL = 3'd0,
        DIR_N     = 3'd1,
        DIR_S     = 3'd2,
        DIR_E     = 3'd3,
        DIR_W     = 3'd4
    } opn_dir_e;

    typedef struct packed {
        reg_data_t  data;
        logic       valid;
        instr_num_t source_instr;
    } operand_t;

    typedef struct packed {
        reg_data_t  data;
        instr_num_t src;
        instr_num_t instr;
        slot_t      slot;
        opn_dir_e   dir;
    } opn_pkt_t;

    // The destination node is {row, col} packed into the low bits of the instruction number.
    function automatic logic [COORD_W-1:0] node_row(input logic [NODE_W-1:0] node);
        return node[NODE_W-1 -: COORD_W];
    endfunction

    function automatic logic [COORD_W-1:0] node_col(input logic [NODE_W-1:0] node);
        return node[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/opn_inject_queue_dir_calc.sv
// Dimension-ordered (X first, then Y) first-hop direction from this node
// towards a destination node. Purely combinational.
module opn_dir_calc
    import opn_inject_queue_pkg::*;
#(
    parameter int ROW_ID = 0,
    parameter int COL_ID = 0
) (
    input  logic [NODE_W-1:0] i_dest_node,
    output opn_dir_e          o_dir
);

    localparam logic [COORD_W-1:0] ROW_C = COORD_W'(ROW_ID);
    localparam logic [COORD_W-1:0] COL_C = COORD_W'(COL_ID);

    logic [COORD_W-1:0] w_row;
    logic [COORD_W-1:0] w_col;

    assign w_row = node_row(i_dest_node);
    assign w_col = node_col(i_dest_node);

    // Resolve the column first; only an aligned column moves on to the row.
    always_comb begin
        o_dir = DIR_LOCAL;
        if (w_col > COL_C) begin
            o_dir = DIR_E;
        end else if (w_col < COL_C) begin
            o_dir = DIR_W;
        end else if (w_row > ROW_C) begin
            o_dir = DIR_S;
        end else if (w_row < ROW_C) begin
            o_dir = DIR_N;
        end
    end

endmodule

// File: rtl/opn_inject_queue.sv
// Operand-network injection queue: splits each fired result into up to two
// per-target packets, buffers them and offers them one at a time on req/ack.
module opn_inject_queue
    import opn_inject_queue_pkg::*;
#(
    parameter int ROW_ID = 0,
    parameter int COL_ID = 0,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   fire_valid,
    output logic                   fire_ready,
    input  reg_data_t              fire_data,
    input  instr_num_t             fire_src,
    input  logic [1:0]             tgt_valid,
    input  instr_num_t [1:0]       tgt_instr,
    input  logic [1:0][1:0]        tgt_slot,
    output logic                   req_out,
    input  logic                   ack_in,
    output operand_t               operand_out,
    output instr_num_t             dest_instr_out,
    output logic [1:0]             dest_slot_out,
    output logic [2:0]             dir_out,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [15:0]            stall_cnt,
    output logic                   slot_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    opn_pkt_t           r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [15:0]        r_stall_cnt;
    logic               r_slot_err;

    logic               w_fire_accept;
    logic               w_pop;
    logic [1:0]         w_lane_push;
    logic [1:0]         w_lane_bad;
    opn_dir_e           w_lane_dir [2];
    opn_pkt_t           w_lane_pkt [2];
    logic [CNT_W-1:0]   w_push_cnt;
    logic [PTR_W-1:0]   w_wr_ptr_lane1;
    opn_pkt_t           w_head;

    // Back-pressure is decided from registered occupancy only, so a fire is never
    // half-accepted and there is no path from the network side back to the tile.
    assign fire_ready    = (r_count <= CNT_W'(DEPTH - 2));
    assign w_fire_accept = fire_valid && fire_ready;
    assign req_out       = (r_count != '0);
    assign w_pop         = req_out && ack_in;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            opn_dir_calc #(
                .ROW_ID (ROW_ID),
                .COL_ID (COL_ID)
            ) u_dir_calc (
                .i_dest_node (tgt_instr[gi][NODE_W-1:0]),
                .o_dir       (w_lane_dir[gi])
            );

            assign w_lane_bad[gi]  = tgt_valid[gi] && (tgt_slot[gi] == SLOT_ILLEGAL);
            // A fire landing in the flush cycle is discarded along with the queue.
            assign w_lane_push[gi] = w_fire_accept && !flush && tgt_valid[gi] &&
                                     (tgt_slot[gi] != SLOT_ILLEGAL);
            assign w_lane_pkt[gi]  = '{data:  fire_data,
                                       src:   fire_src,
                                       instr: tgt_instr[gi],
                                       slot:  tgt_slot[gi],
                                       dir:   w_lane_dir[gi]};
        end
    endgenerate

    // Target 1 lands right behind target 0, or in target 0's place if target 0 was dropped.
    assign w_push_cnt     = CNT_W'(w_lane_push[0]) + CNT_W'(w_lane_push[1]);
    assign w_wr_ptr_lane1 = r_wr_ptr + PTR_W'(w_lane_push[0]);

    // Packet storage; fire_ready guarantees both lanes only ever hit free entries.
    always_ff @(posedge clk) begin
        if (w_lane_push[0]) begin
            r_mem[r_wr_ptr] <= w_lane_pkt[0];
        end
        if (w_lane_push[1]) begin
            r_mem[w_wr_ptr_lane1] <= w_lane_pkt[1];
        end
    end

    // Pointers and occupancy; flush abandons everything including an unacked head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_cnt);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
            r_count  <= r_count + w_push_cnt - CNT_W'(w_pop);
        end
    end

    // Saturating count of cycles the network held off an offered packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (req_out && !ack_in && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    // Sticky flag for any accepted fire that named an illegal slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_err <= 1'b0;
        end else if (w_fire_accept && (|w_lane_bad)) begin
            r_slot_err <= 1'b1;
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign occupancy = r_count;
    assign stall_cnt = r_stall_cnt;
    assign slot_err  = r_slot_err;

    // Head packet drives the network; outputs read zero while nothing is offered.
    always_comb begin
        operand_out    = '0;
        dest_instr_out = '0;
        dest_slot_out  = '0;
        dir_out        = '0;
        if (req_out) begin
            operand_out.data         = w_head.data;
            operand_out.valid        = 1'b1;
            operand_out.source_instr = w_head.src;
            dest_instr_out           = w_head.instr;
            dest_slot_out            = w_head.slot;
            dir_out                  = w_head.dir;
        end
    end

endmodule

// File: tb/tb_opn_inject_queue.sv
// Bench for opn_inject_queue (node row 1, col 1, depth 4): table-driven vectors,
// a packet scoreboard fed at fire time and drained at each handshake, plus
// hand-written stall and asynchronous-reset sequences.
module tb_opn_inject_queue;

    localparam int TB_ROW = 1;
    localparam int TB_COL = 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             fire_valid = 1'b0;
    logic             fire_ready;
    logic [31:0]      fire_data = '0;
    logic [6:0]       fire_src = '0;
    logic [1:0]       tgt_valid = '0;
    logic [1:0][6:0]  tgt_instr = '0;
    logic [1:0][1:0]  tgt_slot = '0;
    logic             req_out;
    logic             ack_in = 1'b0;
    logic [39:0]      op_out;
    logic [6:0]       dest_instr_out;
    logic [1:0]       dest_slot_out;
    logic [2:0]       dir_out;
    logic [2:0]       occupancy;
    logic [15:0]      stall_cnt;
    logic             slot_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    opn_inject_queue #(
        .ROW_ID (TB_ROW),
        .COL_ID (TB_COL),
        .DEPTH  (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .fire_valid     (fire_valid),
        .fire_ready     (fire_ready),
        .fire_data      (fire_data),
        .fire_src       (fire_src),
        .tgt_valid      (tgt_valid),
        .tgt_instr      (tgt_instr),
        .tgt_slot       (tgt_slot),
        .req_out        (req_out),
        .ack_in         (ack_in),
        .operand_out    (op_out),
        .dest_instr_out (dest_instr_out),
        .dest_slot_out  (dest_slot_out),
        .dir_out        (dir_out),
        .occupancy      (occupancy),
        .stall_cnt      (stall_cnt),
        .slot_err       (slot_err)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [6:0]  src;
        logic [6:0]  instr;
        logic [1:0]  slot;
        logic [2:0]  dir;
    } pkt_t;

    typedef struct {
        bit          rst;
        logic        fv;
        logic [1:0]  tv;
        logic [6:0]  i0;
        logic [1:0]  s0;
        logic [6:0]  i1;
        logic [1:0]  s1;
        logic        ack;
        logic        fl;
        logic [31:0] data;
        int          exp_occ;
        logic        exp_rdy;
        logic        exp_req;
        logic        exp_serr;
    } vec_t;

    vec_t vq[$];
    pkt_t m_q[$];
    int   m_stall = 0;
    logic m_serr = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // First hop by XY routing: columns first, then rows.
    function automatic logic [2:0] exp_dir(input logic [6:0] ins);
        int r;
        int c;
        r = int'(ins[3:2]);
        c = int'(ins[1:0]);
        if (c != TB_COL) return (c > TB_COL) ? 3'd3 : 3'd4;
        if (r != TB_ROW) return (r > TB_ROW) ? 3'd2 : 3'd1;
        return 3'd0;
    endfunction

    task automatic drive(input logic fv, input logic [1:0] tv, input logic [6:0] i0, input logic [1:0] s0,
                         input logic [6:0] i1, input logic [1:0] s1, input logic ack, input logic fl,
                         input logic [31:0] data);
        fire_valid   = fv;
        tgt_valid    = tv;
        tgt_instr[0] = i0;
        tgt_slot[0]  = s0;
        tgt_instr[1] = i1;
        tgt_slot[1]  = s1;
        ack_in       = ack;
        flush        = fl;
        fire_data    = data;
        fire_src     = data[6:0] ^ 7'h15;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ack);
        drive(1'b0, 2'b00, 7'h0, 2'd0, 7'h0, 2'd0, ack, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fire_valid = 1'b0;
        tgt_valid = '0;
        ack_in = 1'b0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic av(input bit rst, input logic fv, input logic [1:0] tv, input logic [6:0] i0,
                      input logic [1:0] s0, input logic [6:0] i1, input logic [1:0] s1, input logic ack,
                      input logic fl, input logic [31:0] data, input int occ, input logic rdy,
                      input logic req, input logic serr);
        vec_t v;
        v = '{rst, fv, tv, i0, s0, i1, s1, ack, fl, data, occ, rdy, req, serr};
        vq.push_back(v);
    endtask

    // Scoreboard: compare the DUT against the model mid-cycle, then advance the
    // model with the inputs the DUT will sample at the coming edge.
    initial begin
        int   sz;
        logic acc;
        pkt_t p;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_q.delete();
                m_stall = 0;
                m_serr  = 1'b0;
            end else begin
                sz = m_q.size();
                check("sb_occupancy", occupancy, sz);
                check("sb_fire_ready", fire_ready, (sz <= 2));
                check("sb_req_out", req_out, (sz != 0));
                check("sb_stall_cnt", stall_cnt, m_stall);
                check("sb_slot_err", slot_err, m_serr);
                if (sz != 0) begin
                    p = m_q[0];
                    check("sb_data", op_out[39:8], p.data);
                    check("sb_valid", op_out[7], 1'b1);
                    check("sb_src", op_out[6:0], p.src);
                    check("sb_dest_instr", dest_instr_out, p.instr);
                    check("sb_dest_slot", dest_slot_out, p.slot);
                    check("sb_dir", dir_out, p.dir);
                end else begin
                    check("sb_idle_outputs", {op_out, dest_instr_out, dest_slot_out, dir_out}, 64'd0);
                end
                if (sz != 0 && !ack_in && m_stall != 65535) m_stall++;
                acc = fire_valid && (sz <= 2);
                if (acc) begin
                    for (int l = 0; l < 2; l++) begin
                        if (tgt_valid[l] && tgt_slot[l] == 2'd3) m_serr = 1'b1;
                    end
                end
                if (flush) begin
                    m_q.delete();
                end else begin
                    if (sz != 0 && ack_in) begin
                        $display("pop  data=%h instr=%h slot=%0d dir=%0d", m_q[0].data, m_q[0].instr,
                                 m_q[0].slot, m_q[0].dir);
                        void'(m_q.pop_front());
                    end
                    if (acc) begin
                        for (int l = 0; l < 2; l++) begin
                            if (tgt_valid[l] && tgt_slot[l] != 2'd3) begin
                                p.data  = fire_data;
                                p.src   = fire_src;
                                p.instr = tgt_instr[l];
                                p.slot  = tgt_slot[l];
                                p.dir   = exp_dir(tgt_instr[l]);
                                m_q.push_back(p);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] cap;

        // rst fv  tv     i0     s0 i1     s1 ack fl data          occ rdy req serr
        // dual fire, ack held: E then S
        av(1, 1, 2'b11, 7'h07, 0, 7'h09, 1, 1, 0, 32'h000000A5, 2, 1, 1, 0);
        av(0, 0, 2'b00, 7'h00, 0, 7'h00, 0, 1, 0, 32'h0,        1, 1, 1, 0);
        av(0, 0, 2'b00, 7'h00, 0, 7'h00, 0, 1, 0, 32'h0,        0, 1, 0, 0);
        // fill to full, third fire ignored, drain
        av(1, 1, 2'b11, 7'h04, 2, 7'h01, 0, 0, 0, 32'h11111111, 2, 1, 1, 0);
        av(0, 1, 2'b11, 7'h05, 1, 7'h07, 2, 0, 0, 32'h22222222, 4, 0, 1, 0);
        av(0, 1, 2'b11, 7'h09, 0, 7'h04, 1, 0, 0, 32'h33333333, 4, 0, 1, 0);
        av(0, 0, 2'b00, 7'h00, 0, 7'h00, 0, 1, 0, 32'h0,        3, 0, 1, 0);
        av(0, 0, 2'b00, 7'h00, 0, 7'h00, 0, 1, 0, 32'h0,        2, 1, 1, 0);
        av(0, 0, 2'b00, 7'h00, 0, 7'h00, 0, 1, 0, 32'h0,        1, 1, 1, 0);
        av(0, 0, 2'b00, 7'h00, 0, 7'h00, 0, 1, 0, 32'h0,        0, 1, 0, 0);
        // push and pop in the same cycle at occupancy 2
        av(1, 1, 2'b11, 7'h01, 0, 7'h05, 1, 0, 0, 32'h44444444, 2, 1, 1, 0);
        av(0, 1, 2'b11, 7'h07, 2, 7'h09, 0, 1, 0, 32'h55555555, 3, 0, 1, 0);
        av(0, 0, 2'b00, 7'h00, 0, 7'h00, 0, 1, 0, 32'h0,        2, 1, 1, 0);
        av(0, 0, 2'b00, 7'h00, 0, 7'h00, 0, 1, 0, 32'h0,        1, 1, 1, 0);
        av(0, 0, 2'b00, 7'h00, 0, 7'h00, 0, 1, 0, 32'h0,        0, 1, 0, 0);
        // illegal slot on tgt1, single-target fires, fire with no target
        av(1, 1, 2'b11, 7'h04, 2, 7'h07, 3, 0, 0, 32'h66666666, 1, 1, 1, 1);
        av(0, 0, 2'b00, 7'h00, 0, 7'h00, 0, 1, 0, 32'h0,        0, 1, 0, 1);
        av(0, 1, 2'b01, 7'h09, 1, 7'h00, 0, 0, 0, 32'h77777777, 1, 1, 1, 1);
        av(0, 0, 2'b00, 7'h00, 0, 7'h00, 0, 1, 0, 32'h0,        0, 1, 0, 1);
        av(0, 1, 2'b10, 7'h00, 0, 7'h01, 0, 0, 0, 32'h88888888, 1, 1, 1, 1);
        av(0, 0, 2'b00, 7'h00, 0, 7'h00, 0, 1, 0, 32'h0,        0, 1, 0, 1);
        av(0, 1, 2'b00, 7'h05, 0, 7'h05, 0, 0, 0, 32'h99999999, 0, 1, 0, 1);
        // flush with 3 queued and an unacked head; fire during flush dropped
        av(1, 1, 2'b11, 7'h07, 0, 7'h09, 1, 0, 0, 32'hAAAAAAAA, 2, 1, 1, 0);
        av(0, 1, 2'b01, 7'h04, 2, 7'h00, 0, 0, 0, 32'hBBBBBBBB, 3, 0, 1, 0);
        av(0, 1, 2'b11, 7'h01, 0, 7'h05, 1, 0, 1, 32'hCCCCCCCC, 0, 1, 0, 0);
        av(0, 1, 2'b01, 7'h05, 0, 7'h00, 0, 0, 1, 32'hCDCDCDCD, 0, 1, 0, 0);
        av(0, 1, 2'b01, 7'h05, 0, 7'h00, 0, 0, 0, 32'hDDDDDDDD, 1, 1, 1, 0);
        av(0, 0, 2'b00, 7'h00, 0, 7'h00, 0, 1, 0, 32'h0,        0, 1, 0, 0);

        // Reset state
        do_reset();
        check("rst_req_out", req_out, 1'b0);
        check("rst_fire_ready", fire_ready, 1'b1);
        check("rst_occupancy", occupancy, 3'd0);
        check("rst_stall_cnt", stall_cnt, 16'd0);
        check("rst_slot_err", slot_err, 1'b0);
        check("rst_payload", {op_out, dest_instr_out, dest_slot_out, dir_out}, 64'd0);

        for (int k = 0; k < vq.size(); k++) begin
            if (vq[k].rst) do_reset();
            drive(vq[k].fv, vq[k].tv, vq[k].i0, vq[k].s0, vq[k].i1, vq[k].s1, vq[k].ack, vq[k].fl,
                  vq[k].data);
            $display("vec %0d occ=%0d rdy=%0d req=%0d serr=%0d", k, occupancy, fire_ready, req_out, slot_err);
            check($sformatf("vec%0d_occupancy", k), occupancy, vq[k].exp_occ);
            check($sformatf("vec%0d_fire_ready", k), fire_ready, vq[k].exp_rdy);
            check($sformatf("vec%0d_req_out", k), req_out, vq[k].exp_req);
            check($sformatf("vec%0d_slot_err", k), slot_err, vq[k].exp_serr);
            // First vector: head must be tgt0 heading east, then tgt1 heading south.
            if (k == 0) begin
                check("first_dir_E", dir_out, 3'd3);
                check("first_slot0", dest_slot_out, 2'd0);
                check("first_data", op_out[39:8], 32'hA5);
            end
            if (k == 1) begin
                check("second_dir_S", dir_out, 3'd2);
                check("second_slot1", dest_slot_out, 2'd1);
            end
        end

        // Stall: network holds off for 5 cycles, payload must not move
        do_reset();
        drive(1'b1, 2'b01, 7'h0D, 2'd2, 7'h00, 2'd0, 1'b0, 1'b0, 32'h0000DEAD);
        cap = {op_out, dest_instr_out, dest_slot_out, dir_out};
        check("stall_first_dir_S", dir_out, 3'd2);
        for (int c = 0; c < 5; c++) begin
            idle(1'b0);
            $display("stall cycle %0d stall_cnt=%0d", c, stall_cnt);
            check($sformatf("stall_hold%0d", c), {op_out, dest_instr_out, dest_slot_out, dir_out}, cap);
        end
        check("stall_cnt_5", stall_cnt, 16'd5);
        idle(1'b1);
        check("stall_popped_occ", occupancy, 3'd0);
        check("stall_cnt_kept", stall_cnt, 16'd5);

        // Asynchronous reset in the middle of an offered transfer
        do_reset();
        drive(1'b1, 2'b11, 7'h07, 2'd0, 7'h09, 2'd1, 1'b0, 1'b0, 32'h0BADF00D);
        check("arst_pre_req", req_out, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset asserted mid-cycle req=%0d occ=%0d", req_out, occupancy);
        check("arst_req_drop", req_out, 1'b0);
        check("arst_occupancy", occupancy, 3'd0);
        check("arst_fire_ready", fire_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1'b0);
        check("arst_after_req", req_out, 1'b0);
        check("arst_after_stall", stall_cnt, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
